// File: rtl/pika_pkg.sv
// Shared encodings and screen geometry for the volleyball game blocks
// (referee, ball physics, player/NPC controllers).
package pika_pkg;

  localparam int unsigned VBUF_W       = 320;
  localparam int unsigned VBUF_H       = 240;
  localparam int unsigned BALL_W       = 30;
  localparam int unsigned BALL_H       = 30;
  localparam int unsigned NET_POS_X    = 160;
  localparam int unsigned NET_POS_Y    = 140;
  localparam int unsigned NET_W        = 6;
  localparam int unsigned NET_H        = 80;
  localparam int unsigned FLOOR_MARGIN = 20;

  typedef enum logic [1:0] {
    GS_START = 2'd0,
    GS_WAIT  = 2'd1,
    GS_PLAY  = 2'd2,
    GS_END   = 2'd3
  } game_state_e;

  typedef enum logic {
    SIDE_PLAYER = 1'b0,
    SIDE_NPC    = 1'b1
  } side_e;

endpackage

// File: rtl/game_referee_if.sv
// Referee <-> ball physics link: match state and serve side out, ball position back.
interface game_referee_if;
  logic [11:0] Ball_X;
  logic [11:0] Ball_Y;
  logic [1:0]  Game_state;
  logic        who_win;

  modport master (output Game_state, output who_win, input Ball_X, input Ball_Y);
  modport slave  (input Game_state, input who_win, output Ball_X, output Ball_Y);
endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector for already-synchronised button levels.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;

  // Reset loads 1 so a button held through reset is not seen as a fresh press.
  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b1;
    else       d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/game_referee.sv
// Match controller: start / serve-wait / rally / match-end sequencing,
// floor-touch detection, point awarding and score keeping.
module game_referee
  import pika_pkg::*;
#(
  parameter int unsigned WIN_SCORE        = 5,
  parameter int unsigned DROP_WAIT_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_btn,
  game_referee_if.master        bus,
  output logic [3:0]            player_score,
  output logic [3:0]            npc_score,
  output logic                  match_winner,
  output logic                  point_pulse
);

  localparam int unsigned     CNT_W     = (DROP_WAIT_CYCLES > 1) ? $clog2(DROP_WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DROP_WAIT_CYCLES - 1);
  localparam logic [12:0]     FLOOR_Y   = 13'(VBUF_H - FLOOR_MARGIN);
  localparam logic [12:0]     NET_MID_X = 13'(NET_POS_X + NET_W / 2);
  localparam logic [3:0]      WIN       = 4'(WIN_SCORE);

  game_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pscore_q, pscore_d;
  logic [3:0]       nscore_q, nscore_d;
  side_e            who_q, who_d;
  side_e            mw_q, mw_d;
  logic             pulse_q, pulse_d;
  logic             armed_q;
  logic             start_press;
  logic [12:0]      ball_bot;
  logic [12:0]      ball_mid;
  logic             ground;
  logic [3:0]       inc;

  rise_detect u_start_rise (
    .clk    (clk),
    .reset  (reset),
    .d_i    (start_btn),
    .rise_o (start_press)
  );

  assign ball_bot = {1'b0, bus.Ball_Y} + 13'(BALL_H);
  assign ball_mid = {1'b0, bus.Ball_X} + 13'(BALL_W / 2);
  // armed_q masks the first PLAY cycle, when Ball_Y still holds the pre-serve value.
  assign ground   = (state_q == GS_PLAY) && armed_q && (ball_bot >= FLOOR_Y);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pscore_d = pscore_q;
    nscore_d = nscore_q;
    who_d    = who_q;
    mw_d     = mw_q;
    pulse_d  = 1'b0;
    inc      = '0;
    unique case (state_q)
      GS_START: begin
        if (start_press) begin
          pscore_d = '0;
          nscore_d = '0;
          who_d    = SIDE_PLAYER;
          cnt_d    = '0;
          state_d  = GS_WAIT;
        end
      end
      GS_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = GS_PLAY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GS_PLAY: begin
        if (ground) begin
          pulse_d = 1'b1;
          cnt_d   = '0;
          if (ball_mid < NET_MID_X) begin
            inc      = nscore_q + 4'd1;
            nscore_d = inc;
            who_d    = SIDE_NPC;
          end else begin
            inc      = pscore_q + 4'd1;
            pscore_d = inc;
            who_d    = SIDE_PLAYER;
          end
          if (inc == WIN) begin
            mw_d    = who_d;
            state_d = GS_END;
          end else begin
            state_d = GS_WAIT;
          end
        end
      end
      GS_END: begin
        if (start_press) state_d = GS_START;
      end
      default: state_d = GS_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= GS_START;
      cnt_q    <= '0;
      pscore_q <= '0;
      nscore_q <= '0;
      who_q    <= SIDE_PLAYER;
      mw_q     <= SIDE_PLAYER;
      pulse_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pscore_q <= pscore_d;
      nscore_q <= nscore_d;
      who_q    <= who_d;
      mw_q     <= mw_d;
      pulse_q  <= pulse_d;
      armed_q  <= (state_q == GS_PLAY);
    end
  end

  assign bus.Game_state = state_q;
  assign bus.who_win    = who_q;
  assign player_score   = pscore_q;
  assign npc_score      = nscore_q;
  assign match_winner   = mw_q;
  assign point_pulse    = pulse_q;

endmodule

// File: tb/tb_game_referee.sv
// Directed bench for game_referee with WIN_SCORE=2 and a 4-cycle serve wait.
module tb_game_referee;
  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic [3:0] player_score;
  logic [3:0] npc_score;
  logic       match_winner;
  logic       point_pulse;
  int unsigned checks = 0;
  int unsigned errors = 0;

  game_referee_if bus ();

  game_referee #(.WIN_SCORE(2), .DROP_WAIT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_btn    (start_btn),
    .bus          (bus.master),
    .player_score (player_score),
    .npc_score    (npc_score),
    .match_winner (match_winner),
    .point_pulse  (point_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [1:0] gs, input logic who,
                            input logic [3:0] ps, input logic [3:0] ns,
                            input logic mw, input logic pp);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {bus.Game_state, bus.who_win, player_score, npc_score, match_winner, point_pulse};
    exp = {gs, who, ps, ns, mw, pp};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed gs=%0d who=%0d ps=%0d ns=%0d mw=%0d pp=%0d expected gs=%0d who=%0d ps=%0d ns=%0d mw=%0d pp=%0d",
             tag, obs[12:11], obs[10], obs[9:6], obs[5:2], obs[1], obs[0],
             gs, who, ps, ns, mw, pp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [1:0] gs);
    checks++;
    assert (bus.Game_state === gs) else begin
      errors++;
      $error("FAIL %s observed state=%0d expected state=%0d", tag, bus.Game_state, gs);
    end
  endtask

  // Called right after entering WAIT: three more WAIT cycles, then PLAY.
  task automatic serve_wait(input string tag);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state(tag, 2'd1);
    end
    tick();
    expect_state(tag, 2'd2);
  endtask

  initial begin
    reset      = 1'b1;
    start_btn  = 1'b0;
    bus.Ball_X = 12'd0;
    bus.Ball_Y = 12'd0;
    repeat (3) tick();
    expect_all("reset", 2'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    expect_all("idle", 2'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    start_btn = 1'b1;
    tick();
    expect_all("serve_enter", 2'd1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    serve_wait("serve1");

    bus.Ball_X = 12'd100;
    bus.Ball_Y = 12'd190;
    tick();
    expect_all("stale_mask", 2'd2, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    tick();
    expect_all("left_point", 2'd1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b1);

    bus.Ball_Y = 12'd4095;
    start_btn  = 1'b0;
    tick();
    expect_all("pulse_one", 2'd1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
    start_btn = 1'b1;
    tick();
    expect_all("wait_press_ign", 2'd1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
    tick();
    expect_state("wait_cnt3", 2'd1);
    bus.Ball_X = 12'd140;
    bus.Ball_Y = 12'd189;
    tick();
    expect_all("wait_len", 2'd2, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
    tick();
    tick();
    expect_all("floor_minus1", 2'd2, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    expect_all("play_press_ign", 2'd2, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);

    bus.Ball_Y = 12'd190;
    tick();
    expect_all("left140_npc_wins", 2'd3, 1'b1, 4'd0, 4'd2, 1'b1, 1'b1);
    tick();
    expect_all("end_hold", 2'd3, 1'b1, 4'd0, 4'd2, 1'b1, 1'b0);
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    expect_all("end_to_start", 2'd0, 1'b1, 4'd0, 4'd2, 1'b1, 1'b0);
    tick();
    expect_state("start_needs_press", 2'd0);
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    expect_all("match2_start", 2'd1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);

    bus.Ball_X = 12'd148;
    bus.Ball_Y = 12'd200;
    serve_wait("serve2");
    tick();
    expect_all("mask2", 2'd2, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    tick();
    expect_all("right_point", 2'd1, 1'b0, 4'd1, 4'd0, 1'b1, 1'b1);
    serve_wait("serve3");
    tick();
    tick();
    expect_all("player_wins", 2'd3, 1'b0, 4'd2, 4'd0, 1'b0, 1'b1);
    tick();
    expect_all("no_repeat", 2'd3, 1'b0, 4'd2, 4'd0, 1'b0, 1'b0);

    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    expect_state("m3_start", 2'd0);
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    expect_all("m3_serve", 2'd1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    serve_wait("serve4");
    tick();
    tick();
    expect_all("m3_point", 2'd1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b1);
    serve_wait("serve5");
    tick();
    expect_all("pre_reset", 2'd2, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    expect_all("mid_reset", 2'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    expect_state("held_through_reset", 2'd0);
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    expect_state("repress_after_reset", 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
